bht_writer: RTL and testbench
=============================

# bht_writer

Write-side engine for the 64-entry, 4-way set-associative branch history table (16 sets). It is the only writer of the table. It clears the table after reset, allocates new entries for branches and jumps decoded in ID using per-set FIFO replacement, and applies saturating-counter updates for branches resolved in EXE. It drives a single registered write port into the table storage; the IF and EXE lookup logic only reads that storage.

## Interface
- `ALLOC_Q_DEPTH`, default 2: depth of the deferred-allocation queue; only used with `BHT_ALLOC_QUEUE_EN`.
- Entry format, MSB first: valid [18], tag [17:12], target [11:2], ctr [1:0].

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_alloc`  in  1  ID holds a jump or B-type instruction that missed in the table.
- `id_is_jump`  in  1  qualifies `id_alloc`: 1 = jump, 0 = B-type.
- `id_PC`  in  10  PC of the ID instruction.
- `id_branchtarget`  in  10  target to store in the new entry.
- `exe_upd`  in  1  EXE resolved a B-type instruction that hit in the table.
- `exe_PC`  in  10  PC of the EXE instruction.
- `exe_way`  in  2  way that hit in EXE.
- `exe_entry`  in  19  entry that hit in EXE.
- `exe_taken`  in  1  resolved branch outcome.
- `wr_en`  out  1  table write strobe; storage commits on the next edge.
- `wr_index`  out  6  table index, {set[3:0], way[1:0]}.
- `wr_data`  out  19  entry to write.
- `busy`  out  1  clear sweep in progress.
- `alloc_drop`  out  1  one-cycle pulse: an allocation was discarded.

## Operation
- State machine has two states, SWEEP and RUN.
- **SWEEP**
  - Entered while `rst`=1.
  - Sweep index starts at 0.
  - Each cycle: `wr_en`=1, `wr_index`=sweep index, `wr_data`=0; index increments.
  - After index 63 has been written, go to RUN.
  - `id_alloc` and `exe_upd` are ignored in this state; `alloc_drop` stays 0.
- **RUN**: one write per cycle, priority EXE update > queued allocation > new allocation.
- **EXE update**
  - New counter is `exe_entry[1:0]`+1 if `exe_taken`, else −1, saturating at 3 and 0.
  - Write `exe_entry` with the new counter at index {`exe_PC[3:0]`, `exe_way`}.
  - If the counter is already saturated in the outcome direction, no write is issued and the slot passes to an allocation.
- **Allocation**
  - Set = `id_PC[3:0]`; way = `fifo_ptr[set]`.
  - Data = {1, `id_PC[9:4]`, `id_branchtarget`, ctr}, with ctr = 2'b11 for a jump and 2'b10 for a B-type.
  - `fifo_ptr[set]` increments mod 4 in the same cycle the write is issued, not when the allocation is accepted.
  - There are 16 pointers of 2 bits each; all are 0 after reset.
- **Collision**: an allocation that loses arbitration goes to the queue.
- **Queue behaviour**
  - Queue is FIFO.
  - A queued allocation issues in the first cycle with no EXE write, oldest first.
  - A new `id_alloc` arriving in that cycle enqueues behind it.
  - If the queue is empty and there is no EXE write, a new allocation issues directly.
- **Full queue**: an allocation arriving when the queue is full is dropped with `alloc_drop`=1.
- **Duplicate**: an allocation whose `id_PC` equals a queued entry's PC is dropped silently (`alloc_drop`=0). This prevents two entries with the same tag.

## Timing
- During `rst`=1:
  - `wr_en`=1, `wr_index`=0, `wr_data`=0.
  - `busy`=1, `alloc_drop`=0.
  - Queue is emptied and all pointers are zeroed.
- Sweep writes indices 0..63 on consecutive edges.
- `busy` falls in the cycle after index 63 is presented.
- Reset asserted mid-sweep or mid-RUN restarts the sweep at index 0; queued allocations are lost.
- Latency: inputs sampled at edge N appear on `wr_*` after edge N, and the table commits at edge N+1. All outputs are registered.
- `alloc_drop` is asserted in the cycle following the dropped request.
- Reads in IF and EXE during the cycle a write is presented return the old entry; no bypass.
- An EXE update and an allocation to the same index in one cycle: the EXE write wins and the allocation defers. The deferred allocation later overwrites that entry via the FIFO pointer.

## Configuration
- Macro: `BHT_ALLOC_QUEUE_EN`.
- **Defined**: an `ALLOC_Q_DEPTH`-entry deferred-allocation queue exists, as described above.
- **Undefined**:
  - There is no queue.
  - An allocation that collides with an EXE write is dropped with `alloc_drop`=1.
  - The duplicate check is removed.

## Test plan
- Reset, then release: observe 64 writes, index 0..63, all `wr_data`=0. `busy` falls after index 63. Assert `rst` at index 30: the sweep restarts at 0.
- Five allocations to PCs 0x015, 0x025, 0x035, 0x045, 0x055 (all set 5), all B-type:
  - Ways 0, 1, 2, 3, 0 in order.
  - Data for 0x015 with target 0x100 is {1, 6'h01, 10'h100, 2'b10}.
  - The fifth overwrites index 0x14.
- EXE update at ctr 2'b11 with taken: no write. At ctr 2'b00 with not-taken: no write. At ctr 2'b01 with taken: write ctr 2'b10 to {set, way}.
- Allocation colliding with an EXE write (macro defined): the EXE write is issued first and the allocation follows one cycle later. Same case with macro undefined: `alloc_drop` pulses and no allocation write occurs.
- Queue full (macro defined, depth 2): three collisions back to back give `alloc_drop` on the third only. Re-allocating a queued PC gives no `alloc_drop` and exactly one write for that PC.

Source files
------------

// File: rtl/bht_writer.sv
// Sole write port into the 64-entry, 4-way BHT: post-reset clear sweep, FIFO-replacement
// allocation and saturating counter updates. Define BHT_ALLOC_QUEUE_EN for a deferred-alloc queue.
module bht_writer #(
  parameter int unsigned ALLOC_Q_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        id_alloc,
  input  logic        id_is_jump,
  input  logic [9:0]  id_PC,
  input  logic [9:0]  id_branchtarget,
  input  logic        exe_upd,
  input  logic [9:0]  exe_PC,
  input  logic [1:0]  exe_way,
  input  logic [18:0] exe_entry,
  input  logic        exe_taken,
  output logic        wr_en,
  output logic [5:0]  wr_index,
  output logic [18:0] wr_data,
  output logic        busy,
  output logic        alloc_drop
);

  typedef enum logic [0:0] {StSweep, StRun} state_e;

  state_e      state_q, state_d;
  logic        wr_en_q, wr_en_d;
  logic [5:0]  wr_index_q, wr_index_d;
  logic [18:0] wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        alloc_drop_q, alloc_drop_d;
  logic [1:0]  fifo_ptr_q [16];
  logic [1:0]  fifo_ptr_d [16];

  // Only the set bits of the EXE PC select the entry; the tag comes from exe_entry.
  logic unused_exe_pc;
  assign unused_exe_pc = ^exe_PC[9:4];

  logic [1:0] exe_ctr;
  logic       exe_wr;

  always_comb begin
    exe_ctr = exe_entry[1:0];
    exe_wr  = 1'b0;
    if (exe_taken) begin
      if (exe_entry[1:0] != 2'b11) begin
        exe_ctr = exe_entry[1:0] + 2'd1;
        exe_wr  = exe_upd;
      end
    end else if (exe_entry[1:0] != 2'b00) begin
      exe_ctr = exe_entry[1:0] - 2'd1;
      exe_wr  = exe_upd;
    end
  end

`ifdef BHT_ALLOC_QUEUE_EN
  localparam int unsigned CntW = $clog2(ALLOC_Q_DEPTH + 1);

  logic [9:0]      q_pc_q  [ALLOC_Q_DEPTH];
  logic [9:0]      q_pc_d  [ALLOC_Q_DEPTH];
  logic [9:0]      q_tgt_q [ALLOC_Q_DEPTH];
  logic [9:0]      q_tgt_d [ALLOC_Q_DEPTH];
  logic            q_jmp_q [ALLOC_Q_DEPTH];
  logic            q_jmp_d [ALLOC_Q_DEPTH];
  logic [CntW-1:0] q_cnt_q, q_cnt_d;
  logic            q_dup;

  // A second allocation of a PC already waiting would create two entries with one tag.
  always_comb begin
    q_dup = 1'b0;
    for (int i = 0; i < ALLOC_Q_DEPTH; i++) begin
      if (CntW'(i) < q_cnt_q && q_pc_q[i] == id_PC) q_dup = 1'b1;
    end
  end
`else
  logic unused_depth;
  assign unused_depth = ^ALLOC_Q_DEPTH;
`endif

  logic       alloc_go;
  logic       alloc_jmp;
  logic [9:0] alloc_pc;
  logic [9:0] alloc_tgt;
  logic [3:0] alloc_set;

  always_comb begin
    state_d      = state_q;
    wr_en_d      = 1'b0;
    wr_index_d   = wr_index_q;
    wr_data_d    = '0;
    busy_d       = 1'b0;
    alloc_drop_d = 1'b0;
    fifo_ptr_d   = fifo_ptr_q;
    alloc_go     = 1'b0;
    alloc_jmp    = id_is_jump;
    alloc_pc     = id_PC;
    alloc_tgt    = id_branchtarget;
    alloc_set    = 4'd0;
`ifdef BHT_ALLOC_QUEUE_EN
    q_pc_d       = q_pc_q;
    q_tgt_d      = q_tgt_q;
    q_jmp_d      = q_jmp_q;
    q_cnt_d      = q_cnt_q;
`endif

    unique case (state_q)
      StSweep: begin
        if (wr_index_q == 6'd63) begin
          state_d = StRun;
        end else begin
          wr_en_d    = 1'b1;
          wr_index_d = wr_index_q + 6'd1;
          busy_d     = 1'b1;
        end
      end
      StRun: begin
        if (exe_wr) begin
          wr_en_d    = 1'b1;
          wr_index_d = {exe_PC[3:0], exe_way};
          wr_data_d  = {exe_entry[18:2], exe_ctr};
        end
`ifdef BHT_ALLOC_QUEUE_EN
        else if (q_cnt_q != '0) begin
          alloc_go  = 1'b1;
          alloc_pc  = q_pc_q[0];
          alloc_tgt = q_tgt_q[0];
          alloc_jmp = q_jmp_q[0];
          for (int i = 0; i < ALLOC_Q_DEPTH - 1; i++) begin
            q_pc_d[i]  = q_pc_q[i+1];
            q_tgt_d[i] = q_tgt_q[i+1];
            q_jmp_d[i] = q_jmp_q[i+1];
          end
          q_cnt_d = q_cnt_q - CntW'(1);
        end else if (id_alloc) begin
          alloc_go = 1'b1;
        end

        if (id_alloc && (exe_wr || q_cnt_q != '0) && !q_dup) begin
          if (q_cnt_q == CntW'(ALLOC_Q_DEPTH)) begin
            alloc_drop_d = 1'b1;
          end else begin
            for (int i = 0; i < ALLOC_Q_DEPTH; i++) begin
              if (CntW'(i) == q_cnt_d) begin
                q_pc_d[i]  = id_PC;
                q_tgt_d[i] = id_branchtarget;
                q_jmp_d[i] = id_is_jump;
              end
            end
            q_cnt_d = q_cnt_d + CntW'(1);
          end
        end
`else
        else if (id_alloc) begin
          alloc_go = 1'b1;
        end
        alloc_drop_d = id_alloc & exe_wr;
`endif

        // Pointer advances when the write issues, so queued entries take the way current then.
        if (alloc_go) begin
          alloc_set             = alloc_pc[3:0];
          wr_en_d               = 1'b1;
          wr_index_d            = {alloc_set, fifo_ptr_q[alloc_set]};
          wr_data_d             = {1'b1, alloc_pc[9:4], alloc_tgt, alloc_jmp ? 2'b11 : 2'b10};
          fifo_ptr_d[alloc_set] = fifo_ptr_q[alloc_set] + 2'd1;
        end
      end
      default: state_d = StSweep;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q      <= StSweep;
      wr_en_q      <= 1'b1;
      wr_index_q   <= 6'd0;
      wr_data_q    <= '0;
      busy_q       <= 1'b1;
      alloc_drop_q <= 1'b0;
      fifo_ptr_q   <= '{default: 2'd0};
`ifdef BHT_ALLOC_QUEUE_EN
      q_cnt_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wr_en_q      <= wr_en_d;
      wr_index_q   <= wr_index_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      alloc_drop_q <= alloc_drop_d;
      fifo_ptr_q   <= fifo_ptr_d;
`ifdef BHT_ALLOC_QUEUE_EN
      q_cnt_q      <= q_cnt_d;
`endif
    end
  end

`ifdef BHT_ALLOC_QUEUE_EN
  // Payload needs no reset; occupancy alone marks entries live.
  always_ff @(posedge CLK) begin
    q_pc_q  <= q_pc_d;
    q_tgt_q <= q_tgt_d;
    q_jmp_q <= q_jmp_d;
  end
`endif

  assign wr_en      = wr_en_q;
  assign wr_index   = wr_index_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign alloc_drop = alloc_drop_q;

endmodule

// File: tb/tb_bht_writer.sv
// Scoreboard bench for bht_writer: expected writes/drops are queued by the stimulus and
// consumed by a negedge monitor. Covers both BHT_ALLOC_QUEUE_EN builds.
module tb_bht_writer;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        id_alloc = 1'b0;
  logic        id_is_jump = 1'b0;
  logic [9:0]  id_PC = '0;
  logic [9:0]  id_branchtarget = '0;
  logic        exe_upd = 1'b0;
  logic [9:0]  exe_PC = '0;
  logic [1:0]  exe_way = '0;
  logic [18:0] exe_entry = '0;
  logic        exe_taken = 1'b0;
  logic        wr_en;
  logic [5:0]  wr_index;
  logic [18:0] wr_data;
  logic        busy;
  logic        alloc_drop;

  always #5 CLK = ~CLK;

  bht_writer #(.ALLOC_Q_DEPTH(2)) dut (
    .CLK             (CLK),
    .rst             (rst),
    .id_alloc        (id_alloc),
    .id_is_jump      (id_is_jump),
    .id_PC           (id_PC),
    .id_branchtarget (id_branchtarget),
    .exe_upd         (exe_upd),
    .exe_PC          (exe_PC),
    .exe_way         (exe_way),
    .exe_entry       (exe_entry),
    .exe_taken       (exe_taken),
    .wr_en           (wr_en),
    .wr_index        (wr_index),
    .wr_data         (wr_data),
    .busy            (busy),
    .alloc_drop      (alloc_drop)
  );

  typedef struct packed {
    logic        is_drop;
    logic [5:0]  idx;
    logic [18:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  int   k;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic exp_wr(input logic [5:0] idx, input logic [18:0] data);
    exp_q.push_back('{1'b0, idx, data});
  endtask

  task automatic exp_drop();
    exp_q.push_back('{1'b1, 6'd0, 19'd0});
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic idle();
    id_alloc = 1'b0; id_is_jump = 1'b0; id_PC = '0; id_branchtarget = '0;
    exe_upd = 1'b0; exe_PC = '0; exe_way = '0; exe_entry = '0; exe_taken = 1'b0;
  endtask

  task automatic alloc(input logic jmp, input logic [9:0] pc, input logic [9:0] tgt);
    id_alloc = 1'b1; id_is_jump = jmp; id_PC = pc; id_branchtarget = tgt;
  endtask

  task automatic upd(input logic [9:0] pc, input logic [1:0] way, input logic [18:0] entry,
                     input logic taken);
    exe_upd = 1'b1; exe_PC = pc; exe_way = way; exe_entry = entry; exe_taken = taken;
  endtask

  // Releases reset with index 0 on the outputs and expects indices 1..63 to follow.
  task automatic sweep_from_reset(input string name);
    int n;
    n = 0;
    for (int i = 1; i < 64; i++) exp_wr(6'(i), 19'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    do begin
      @(negedge CLK);
      n++;
    end while (busy && n < 100);
    check({name, " busy fall cycle"}, n, 64);
    #1;
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      if (alloc_drop) begin
        checks++;
        if (exp_q.size() == 0 || !exp_q[0].is_drop) begin
          errors++;
          $display("FAIL drop: alloc_drop=1, expected no drop");
        end else begin
          void'(exp_q.pop_front());
        end
      end
      if (wr_en) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0].is_drop) begin
          errors++;
          $display("FAIL write: unexpected write idx %0h data %0h", wr_index, wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.idx !== wr_index || mon_e.data !== wr_data) begin
            errors++;
            $display("FAIL write: got idx %0h data %0h, expected idx %0h data %0h",
                     wr_index, wr_data, mon_e.idx, mon_e.data);
          end
        end
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst wr_en", wr_en, 1);
    check("rst wr_index", wr_index, 0);
    check("rst wr_data", wr_data, 0);
    check("rst busy", busy, 1);
    check("rst alloc_drop", alloc_drop, 0);
    #1;
    sweep_from_reset("sweep1");

    // Reset in the middle of a sweep restarts it at index 0
    mon_en = 1'b0;
    rst = 1'b1;
    tick();
    check("rerst wr_index", wr_index, 0);
    rst = 1'b0;
    k = 0;
    while (wr_index != 6'd30 && k < 100) begin
      tick();
      k++;
    end
    check("sweep reached 30", wr_index, 30);
    rst = 1'b1;
    tick();
    check("restart wr_index", wr_index, 0);
    check("restart wr_en", wr_en, 1);
    check("restart busy", busy, 1);
    sweep_from_reset("sweep2");

    // FIFO replacement in set 5, then a jump in set 7
    idle();
    alloc(1'b0, 10'h015, 10'h100); exp_wr(6'h14, 19'h41402); tick();
    alloc(1'b0, 10'h025, 10'h104); exp_wr(6'h15, {1'b1, 6'h02, 10'h104, 2'b10}); tick();
    alloc(1'b0, 10'h035, 10'h108); exp_wr(6'h16, {1'b1, 6'h03, 10'h108, 2'b10}); tick();
    alloc(1'b0, 10'h045, 10'h10C); exp_wr(6'h17, {1'b1, 6'h04, 10'h10C, 2'b10}); tick();
    alloc(1'b0, 10'h055, 10'h110); exp_wr(6'h14, {1'b1, 6'h05, 10'h110, 2'b10}); tick();
    alloc(1'b1, 10'h3A7, 10'h2AA); exp_wr(6'h1C, {1'b1, 6'h3A, 10'h2AA, 2'b11}); tick();
    idle(); tick(); tick();

    // Counter updates: saturated ones produce no write
    upd(10'h123, 2'd2, {1'b1, 6'h12, 10'h0AB, 2'b11}, 1'b1); tick();
    upd(10'h123, 2'd2, {1'b1, 6'h12, 10'h0AB, 2'b00}, 1'b0); tick();
    upd(10'h123, 2'd2, {1'b1, 6'h12, 10'h0AB, 2'b01}, 1'b1);
    exp_wr(6'h0E, {1'b1, 6'h12, 10'h0AB, 2'b10}); tick();
    upd(10'h123, 2'd2, {1'b1, 6'h12, 10'h0AB, 2'b10}, 1'b0);
    exp_wr(6'h0E, {1'b1, 6'h12, 10'h0AB, 2'b01}); tick();
    idle(); tick();

    // Saturated update hands the slot to a same-cycle allocation
    upd(10'h123, 2'd1, {1'b1, 6'h12, 10'h0AB, 2'b11}, 1'b1);
    alloc(1'b0, 10'h0A9, 10'h033);
    exp_wr(6'h24, {1'b1, 6'h0A, 10'h033, 2'b10}); tick();
    idle(); tick();

    // Collision between an EXE write and an allocation in set 6
    upd(10'h246, 2'd1, {1'b1, 6'h24, 10'h155, 2'b10}, 1'b1);
    alloc(1'b0, 10'h066, 10'h0F0);
`ifdef BHT_ALLOC_QUEUE_EN
    exp_wr(6'h19, {1'b1, 6'h24, 10'h155, 2'b11});
    exp_wr(6'h18, {1'b1, 6'h06, 10'h0F0, 2'b10});
`else
    exp_drop();
    exp_wr(6'h19, {1'b1, 6'h24, 10'h155, 2'b11});
`endif
    tick();
    idle(); tick(); tick();
    alloc(1'b0, 10'h076, 10'h0F4);
`ifdef BHT_ALLOC_QUEUE_EN
    exp_wr(6'h19, {1'b1, 6'h07, 10'h0F4, 2'b10});
`else
    exp_wr(6'h18, {1'b1, 6'h07, 10'h0F4, 2'b10});
`endif
    tick();
    idle(); tick();

`ifdef BHT_ALLOC_QUEUE_EN
    // Queue full: the third back-to-back collision is dropped
    upd(10'h013, 2'd0, {1'b1, 6'h01, 10'h011, 2'b00}, 1'b1);
    alloc(1'b0, 10'h0B1, 10'h101);
    exp_wr(6'h0C, {1'b1, 6'h01, 10'h011, 2'b01}); tick();
    alloc(1'b0, 10'h0C2, 10'h102);
    exp_wr(6'h0C, {1'b1, 6'h01, 10'h011, 2'b01}); tick();
    alloc(1'b0, 10'h0D3, 10'h103);
    exp_drop();
    exp_wr(6'h0C, {1'b1, 6'h01, 10'h011, 2'b01}); tick();
    idle();
    exp_wr(6'h04, {1'b1, 6'h0B, 10'h101, 2'b10});
    exp_wr(6'h08, {1'b1, 6'h0C, 10'h102, 2'b10});
    tick(); tick(); tick();

    // Re-allocating a queued PC is dropped silently and written once
    upd(10'h013, 2'd0, {1'b1, 6'h01, 10'h011, 2'b00}, 1'b1);
    alloc(1'b0, 10'h0E4, 10'h1E4);
    exp_wr(6'h0C, {1'b1, 6'h01, 10'h011, 2'b01}); tick();
    alloc(1'b0, 10'h0E4, 10'h1E4);
    exp_wr(6'h0C, {1'b1, 6'h01, 10'h011, 2'b01}); tick();
    idle();
    exp_wr(6'h10, {1'b1, 6'h0E, 10'h1E4, 2'b10});
    tick(); tick(); tick();
`endif

    tick(); tick();
    check("scoreboard drained", exp_q.size(), 0);
    check("final busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
